vdp_vga_timing: RTL



---
 rtl/vdp_vga_timing.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vdp_vga_timing.sv
// VGA 640x480@60 raster generator for the VDP video path (256x192 scaled 2x, centred in a border).
// Optional build macro VDP_VGA_FRAME_IRQ_EN adds a sticky frame interrupt (irq_ack / frame_irq).
module vdp_vga_timing #(
    parameter int CLK_PER_PX = 2,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int ACT_X0     = 64,
    parameter int ACT_W      = 512,
    parameter int ACT_Y0     = 48,
    parameter int ACT_H      = 384
) (
    input  logic       pxclk,
    input  logic       reset_n,
`ifdef VDP_VGA_FRAME_IRQ_EN
    input  logic       irq_ack,
    output logic       frame_irq,
`endif
    output logic [9:0] px_col,
    output logic [9:0] px_row,
    output logic       hsync,
    output logic       vsync,
    output logic       bdr_active,
    output logic       vid_active,
    output logic       vid_active0,
    output logic       sprite_tick,
    output logic       last_pixel,
    output logic       col_last,
    output logic       row_last
);

    localparam int              PW       = (CLK_PER_PX > 1) ? $clog2(CLK_PER_PX) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_PER_PX - 1);
    localparam logic [9:0]      COL_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]      ROW_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]      HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]      HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]      VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]      VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]      H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]      V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]      LP_COL   = 10'(H_VIS - 1);
    localparam logic [9:0]      LP_ROW   = 10'(V_VIS - 1);
    localparam logic [9:0]      AX0      = 10'(ACT_X0);
    localparam logic [9:0]      AX1      = 10'(ACT_X0 + ACT_W);
    localparam logic [9:0]      AY0      = 10'(ACT_Y0);
    localparam logic [9:0]      AY1      = 10'(ACT_Y0 + ACT_H);
    localparam logic [10:0]     SPR_Y0   = 11'(ACT_Y0);
    localparam logic [10:0]     SPR_Y1   = 11'(ACT_Y0 + ACT_H);

    logic [PW-1:0] r_pre;
    logic [9:0]    r_col;
    logic [9:0]    r_row;
    logic          r_hsync, r_vsync, r_bdr, r_vid, r_row_last;
    logic          r_spr, r_last_px, r_col_last;

    logic          w_pre_wrap;
    logic [PW-1:0] w_pre_nxt;
    logic [9:0]    w_col_nxt;
    logic [9:0]    w_row_nxt;
    logic [10:0]   w_row_p1;
    logic          w_pulse, w_hsync_nxt, w_vsync_nxt, w_bdr_nxt, w_vid_nxt;
    logic          w_row_last_nxt, w_spr_nxt, w_last_px_nxt, w_col_last_nxt;

    // Next raster position: prescaler, then column, then line.
    always_comb begin
        w_pre_wrap = (r_pre == PRE_LAST);
        w_pre_nxt  = w_pre_wrap ? {PW{1'b0}} : (r_pre + PW'(1));
        w_col_nxt  = r_col;
        w_row_nxt  = r_row;
        if (w_pre_wrap) begin
            if (r_col == COL_LAST) begin
                w_col_nxt = 10'd0;
                w_row_nxt = (r_row == ROW_LAST) ? 10'd0 : (r_row + 10'd1);
            end else begin
                w_col_nxt = r_col + 10'd1;
            end
        end else begin
            w_col_nxt = r_col;
        end
    end

    // Outputs are decoded from the next position so each flop lines up with the counters it describes.
    assign w_row_p1       = {1'b0, w_row_nxt} + 11'd1;
    assign w_pulse        = (w_pre_nxt == PRE_LAST);
    assign w_hsync_nxt    = !((w_col_nxt >= HS_BEG) && (w_col_nxt < HS_END));
    assign w_vsync_nxt    = !((w_row_nxt >= VS_BEG) && (w_row_nxt < VS_END));
    assign w_bdr_nxt      = (w_col_nxt < H_VIS_C) && (w_row_nxt < V_VIS_C);
    assign w_vid_nxt      = (w_col_nxt >= AX0) && (w_col_nxt < AX1) &&
                            (w_row_nxt >= AY0) && (w_row_nxt < AY1);
    assign w_row_last_nxt = (w_row_nxt == ROW_LAST);
    assign w_col_last_nxt = w_pulse && (w_col_nxt == COL_LAST);
    assign w_last_px_nxt  = w_pulse && (w_col_nxt == LP_COL) && (w_row_nxt == LP_ROW);
    assign w_spr_nxt      = w_pulse && (w_col_nxt == H_VIS_C) &&
                            (w_row_p1 >= SPR_Y0) && (w_row_p1 < SPR_Y1);

    // Raster counters.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= {PW{1'b0}};
            r_col <= 10'd0;
            r_row <= 10'd0;
        end else begin
            r_pre <= w_pre_nxt;
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // Registered level flags and strobes.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_bdr      <= 1'b0;
            r_vid      <= 1'b0;
            r_row_last <= 1'b0;
            r_spr      <= 1'b0;
            r_last_px  <= 1'b0;
            r_col_last <= 1'b0;
        end else begin
            r_hsync    <= w_hsync_nxt;
            r_vsync    <= w_vsync_nxt;
            r_bdr      <= w_bdr_nxt;
            r_vid      <= w_vid_nxt;
            r_row_last <= w_row_last_nxt;
            r_spr      <= w_spr_nxt;
            r_last_px  <= w_last_px_nxt;
            r_col_last <= w_col_last_nxt;
        end
    end

`ifdef VDP_VGA_FRAME_IRQ_EN
    logic r_frame_irq;

    // Sticky frame interrupt; a set in the same cycle as an ack wins.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_irq <= 1'b0;
        end else if (r_last_px) begin
            r_frame_irq <= 1'b1;
        end else if (irq_ack) begin
            r_frame_irq <= 1'b0;
        end else begin
            r_frame_irq <= r_frame_irq;
        end
    end

    assign frame_irq = r_frame_irq;
`endif

    assign px_col      = r_col;
    assign px_row      = r_row;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign bdr_active  = r_bdr;
    assign vid_active  = r_vid;
    assign vid_active0 = w_vid_nxt;
    assign sprite_tick = r_spr;
    assign last_pixel  = r_last_px;
    assign col_last    = r_col_last;
    assign row_last    = r_row_last;

endmodule
